// File: rtl/pwm_reg_arbiter.sv
// pwm_reg_arbiter
//   Shares the single PWM register-file port between two requesters using
//   round-robin arbitration with a valid/ready handshake. Writes to PERIOD,
//   DUTY1 and DUTY2 (addr 1..3) can be held until the PWM period boundary so
//   the running waveform never sees a half-updated configuration.
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata       requester N transaction (N = 0, 1)
//   reqN_ready                     combinational grant, accept = valid && ready
//   reqN_rvalid/rdata              read return pulse and held read data
//   pwm_en, cycle_end              PWM running flag and period-boundary pulse
//   reg_wr_en/rd_en/addr/wr_data   registered register-block command
//   reg_rd_data                    register-block read data (cycle after rd_en)
//   busy                           a transaction is in flight
module pwm_reg_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned SYNC_UPD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [WIDTH-1:0]  req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [WIDTH-1:0]  req1_rdata,
  input  logic              pwm_en,
  input  logic              cycle_end,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [WIDTH-1:0]  reg_wr_data,
  input  logic [WIDTH-1:0]  reg_rd_data,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_WR,
    S_WAIT_SYNC,
    S_ISSUE_RD,
    S_RD_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;    // index of the requester granted last
  logic                owner_q, owner_d;  // requester owning the transaction in flight
  logic                reg_wr_en_q, reg_wr_en_d;
  logic                reg_rd_en_q, reg_rd_en_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [WIDTH-1:0]    reg_wr_data_q, reg_wr_data_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic [WIDTH-1:0]    rdata0_q, rdata0_d;
  logic [WIDTH-1:0]    rdata1_q, rdata1_d;

  logic                grant0, grant1;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WIDTH-1:0]    sel_wdata;
  logic                sel_deferred;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    reg_wr_en_d   = 1'b0;
    reg_rd_en_d   = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    grant0        = 1'b0;
    grant1        = 1'b0;

    sel_we    = grant1 ? req1_we    : req0_we;
    sel_addr  = grant1 ? req1_addr  : req0_addr;
    sel_wdata = grant1 ? req1_wdata : req0_wdata;
    sel_deferred = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Both valid: the one not granted last wins; otherwise the lone valid one.
        if (!rst) begin
          if (req0_valid && (!req1_valid || last_q)) grant0 = 1'b1;
          else if (req1_valid)                       grant1 = 1'b1;
        end
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
        sel_deferred = (SYNC_UPD != 0) && pwm_en &&
                       (sel_addr >= ADDR_W'(1)) && (sel_addr <= ADDR_W'(3));
        if (grant0 || grant1) begin
          owner_d       = grant1;
          last_d        = grant1;
          reg_addr_d    = sel_addr;
          reg_wr_data_d = sel_wdata;
          if (sel_we) begin
            if (sel_deferred) begin
              state_d = S_WAIT_SYNC;
            end else begin
              state_d     = S_ISSUE_WR;
              reg_wr_en_d = 1'b1;
            end
          end else begin
            state_d     = S_ISSUE_RD;
            reg_rd_en_d = 1'b1;
          end
        end
      end
      S_ISSUE_WR: state_d = S_IDLE;
      S_WAIT_SYNC: begin
        if (cycle_end || !pwm_en) begin
          state_d     = S_ISSUE_WR;
          reg_wr_en_d = 1'b1;
        end
      end
      S_ISSUE_RD: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        state_d = S_IDLE;
        if (owner_q) begin
          rdata1_d  = reg_rd_data;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = reg_rd_data;
          rvalid0_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_q        <= 1'b1;  // req0 wins the first tie after reset
      owner_q       <= 1'b0;
      reg_wr_en_q   <= 1'b0;
      reg_rd_en_q   <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_rd_en_q   <= reg_rd_en_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_rd_en   = reg_rd_en_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Testbench for pwm_reg_arbiter: directed scenarios followed by random
// transactions, checked against a transaction-level expectation model.
module tb_pwm_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [3:0]  req0_addr = '0;
  logic [15:0] req0_wdata = '0;
  logic        req0_ready, req0_rvalid;
  logic [15:0] req0_rdata;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [3:0]  req1_addr = '0;
  logic [15:0] req1_wdata = '0;
  logic        req1_ready, req1_rvalid;
  logic [15:0] req1_rdata;
  logic        pwm_en = 1'b0, cycle_end = 1'b0;
  logic        reg_wr_en, reg_rd_en;
  logic [3:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic [15:0] reg_rd_data = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectation model state
  int          m_last = 1;
  logic [15:0] exp_mem   [16];
  logic [15:0] exp_rdata [2];

  // Stand-in for the PWM register block
  logic [15:0] stub_mem [16] = '{default: '0};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_wr_en) stub_mem[reg_addr] <= reg_wr_data;
    if (reg_rd_en) reg_rd_data <= stub_mem[reg_addr];
  end

  pwm_reg_arbiter #(.WIDTH(16), .ADDR_W(4), .SYNC_UPD(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .pwm_en(pwm_en), .cycle_end(cycle_end),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m_last = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // One complete transaction from an idle arbiter back to idle.
  task automatic run_txn(input bit v0, input bit w0, input logic [3:0] a0, input logic [15:0] d0,
                         input bit v1, input bit w1, input logic [3:0] a1, input logic [15:0] d1,
                         input bit pwm, input int delay, input bit rel_pwm, input bit ce_acc);
    int win;
    int oth;
    bit w;
    bit deferred;
    logic [3:0]  a;
    logic [15:0] d;
    pwm_en = pwm; cycle_end = ce_acc;
    req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    #1;
    if (v0 && v1) win = (m_last == 0) ? 1 : 0;
    else if (v0)  win = 0;
    else if (v1)  win = 1;
    else          win = -1;
    chk("ready0", 32'(req0_ready), 32'(win == 0));
    chk("ready1", 32'(req1_ready), 32'(win == 1));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; cycle_end = 1'b0;
    if (win < 0) begin
      chk("idle_no_accept_busy", 32'(busy), 32'(0));
      return;
    end
    m_last = win;
    oth = 1 - win;
    w = (win == 1) ? w1 : w0;
    a = (win == 1) ? a1 : a0;
    d = (win == 1) ? d1 : d0;
    if (w) begin
      deferred = pwm && (a >= 4'd1) && (a <= 4'd3);
      if (deferred) begin
        for (int i = 0; i < delay; i++) begin
          chk("wait_wr_en", 32'(reg_wr_en), 32'(0));
          chk("wait_busy", 32'(busy), 32'(1));
          if (i == 0) begin
            if (oth == 0) req0_valid = 1'b1; else req1_valid = 1'b1;
            #1;
            chk("wait_other_ready", 32'(oth == 0 ? req0_ready : req1_ready), 32'(0));
          end
          tick();
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
        if (rel_pwm) pwm_en = 1'b0; else cycle_end = 1'b1;
        tick();
        cycle_end = 1'b0;
      end
      chk("wr_en", 32'(reg_wr_en), 32'(1));
      chk("wr_rd_en", 32'(reg_rd_en), 32'(0));
      chk("wr_addr", 32'(reg_addr), 32'(a));
      chk("wr_data", 32'(reg_wr_data), 32'(d));
      chk("wr_busy", 32'(busy), 32'(1));
      exp_mem[a] = d;
      tick();
      chk("wr_en_done", 32'(reg_wr_en), 32'(0));
      chk("wr_idle", 32'(busy), 32'(0));
    end else begin
      chk("rd_en", 32'(reg_rd_en), 32'(1));
      chk("rd_wr_en", 32'(reg_wr_en), 32'(0));
      chk("rd_addr", 32'(reg_addr), 32'(a));
      tick();
      chk("rd_en_done", 32'(reg_rd_en), 32'(0));
      chk("rd_early_rvalid", 32'({req1_rvalid, req0_rvalid}), 32'(0));
      tick();
      exp_rdata[win] = exp_mem[a];
      chk("rvalid0", 32'(req0_rvalid), 32'(win == 0));
      chk("rvalid1", 32'(req1_rvalid), 32'(win == 1));
      chk("rdata0", 32'(req0_rdata), 32'(exp_rdata[0]));
      chk("rdata1", 32'(req1_rdata), 32'(exp_rdata[1]));
      chk("rd_idle", 32'(busy), 32'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    #2;
    do_reset();

    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wr_en", 32'(reg_wr_en), 32'(0));
    chk("rst_rd_en", 32'(reg_rd_en), 32'(0));
    chk("rst_addr", 32'(reg_addr), 32'(0));
    chk("rst_wdata", 32'(reg_wr_data), 32'(0));
    chk("rst_rvalid", 32'({req1_rvalid, req0_rvalid}), 32'(0));
    chk("rst_rdata0", 32'(req0_rdata), 32'(0));
    chk("rst_rdata1", 32'(req1_rdata), 32'(0));

    // Plain write, PWM stopped
    run_txn(1, 1, 4'd2, 16'h0100, 0, 0, 4'd0, 16'h0, 0, 0, 0, 0);

    // Tie-break after reset then alternation
    do_reset();
    run_txn(1, 1, 4'd5, 16'h1111, 1, 1, 4'd6, 16'h2222, 0, 0, 0, 0);
    run_txn(1, 1, 4'd5, 16'h3333, 1, 1, 4'd6, 16'h4444, 0, 0, 0, 0);
    run_txn(1, 1, 4'd5, 16'h5555, 1, 1, 4'd6, 16'h6666, 0, 0, 0, 0);

    // Deferred write released by cycle_end 10 cycles later (cycle_end at accept ignored)
    run_txn(0, 0, 4'd0, 16'h0, 1, 1, 4'd3, 16'h0080, 1, 10, 0, 1);
    // CTRL write is never deferred
    run_txn(1, 1, 4'd0, 16'h0001, 0, 0, 4'd0, 16'h0, 1, 0, 0, 1);
    // Read back through req1
    run_txn(1, 1, 4'd1, 16'h03E7, 0, 0, 4'd0, 16'h0, 0, 0, 0, 0);
    run_txn(0, 0, 4'd0, 16'h0, 1, 0, 4'd1, 16'h0, 0, 0, 0, 0);
    // Deferred write released by pwm_en dropping
    run_txn(1, 1, 4'd2, 16'hA5A5, 0, 0, 4'd0, 16'h0, 1, 2, 1, 0);

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
              1'($urandom), int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
    end

    // Reset while a deferred write waits: the write must be dropped
    pwm_en = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'd2; req0_wdata = 16'hBEEF;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("defer_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_wr_en", 32'(reg_wr_en), 32'(0));
    for (int i = 0; i < 3; i++) begin
      cycle_end = 1'b1;
      tick();
      cycle_end = 1'b0;
      chk("rst_mid_no_wr", 32'(reg_wr_en), 32'(0));
    end
    chk("rst_mid_rvalid", 32'({req1_rvalid, req0_rvalid}), 32'(0));
    run_txn(1, 0, 4'd2, 16'h0, 0, 0, 4'd0, 16'h0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
